// File: rtl/sprite_reg_bank.sv
// Shadow/active per-sprite register bank. Host traffic lands in the shadow bank;
// a commit copies shadow into active one sprite per cycle for the renderer.
//
// state | meaning
// IDLE  | waiting for commit_req; active bank stable
// COPY  | copying shadow[copy_idx] into active[copy_idx], one sprite per cycle
`timescale 1ns/1ps
module sprite_reg_bank #(
  parameter int NUM_SPRITES       = 16,
  parameter int SPRITE_INDEX_BITS = 4,
  parameter int NUM_SPRITE_REGS   = 8,
  parameter int REG_INDEX_BITS    = 3,
  parameter int REG_DATA_WIDTH    = 16
) (
  input  logic                                      clk,
  input  logic                                      _reset,
  input  logic                                      host_en,
  input  logic                                      host_wr,
  input  logic                                      host_rd,
  input  logic [SPRITE_INDEX_BITS+REG_INDEX_BITS-1:0] host_addr,
  input  logic [REG_DATA_WIDTH-1:0]                 host_data_in,
  output logic [REG_DATA_WIDTH-1:0]                 host_data_out,
  input  logic                                      commit_req,
  output logic                                      commit_busy,
  output logic                                      commit_done,
  input  logic [SPRITE_INDEX_BITS-1:0]              disp_index,
  output logic [NUM_SPRITE_REGS*REG_DATA_WIDTH-1:0] disp_reg_values
);

  localparam int ADDR_BITS = SPRITE_INDEX_BITS + REG_INDEX_BITS;
  localparam logic [SPRITE_INDEX_BITS-1:0] LAST_IDX = SPRITE_INDEX_BITS'(NUM_SPRITES - 1);

  typedef enum logic {IDLE, COPY} state_t;

  state_t                         state, state_nxt;
  logic [SPRITE_INDEX_BITS-1:0]   copy_idx;
  logic                           done_q;
  logic                           last_copy;
  logic [SPRITE_INDEX_BITS-1:0]   host_sprite;
  logic [REG_INDEX_BITS-1:0]      host_reg;

  logic [REG_DATA_WIDTH-1:0] shadow [NUM_SPRITES][NUM_SPRITE_REGS];
  logic [REG_DATA_WIDTH-1:0] active [NUM_SPRITES][NUM_SPRITE_REGS];

  assign host_sprite = host_addr[ADDR_BITS-1:REG_INDEX_BITS];
  assign host_reg    = host_addr[REG_INDEX_BITS-1:0];
  assign last_copy   = (state == COPY) && (copy_idx == LAST_IDX);

  // Shadow bank: host writes accepted in any state.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      for (int s = 0; s < NUM_SPRITES; s++)
        for (int r = 0; r < NUM_SPRITE_REGS; r++)
          shadow[s][r] <= '0;
    end else if (host_en && host_wr) begin
      shadow[host_sprite][host_reg] <= host_data_in;
    end
  end

  // Read sees the pre-write value when read and write coincide.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset)
      host_data_out <= '0;
    else if (host_en && host_rd)
      host_data_out <= shadow[host_sprite][host_reg];
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      for (int s = 0; s < NUM_SPRITES; s++)
        for (int r = 0; r < NUM_SPRITE_REGS; r++)
          active[s][r] <= '0;
    end else if (state == COPY) begin
      for (int r = 0; r < NUM_SPRITE_REGS; r++)
        active[copy_idx][r] <= shadow[copy_idx][r];
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      disp_reg_values <= '0;
    end else begin
      for (int r = 0; r < NUM_SPRITE_REGS; r++)
        disp_reg_values[r*REG_DATA_WIDTH +: REG_DATA_WIDTH] <= active[disp_index][r];
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state    <= IDLE;
      copy_idx <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= last_copy;
      if (state == COPY && !last_copy)
        copy_idx <= copy_idx + SPRITE_INDEX_BITS'(1);
      else
        copy_idx <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit_req) state_nxt = COPY;
      COPY:    if (last_copy)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    commit_busy = (state == COPY);
    commit_done = done_q;
  end

endmodule

// File: doc/sprite_reg_bank.md
Name: sprite_reg_bank

Overview:
- Host-side writer and storage for per-sprite registers: the producer of the flat per-sprite register vector that the sprite decoder consumes.
- Host (MCU bus) writes go to a shadow bank.
- On a commit request (issued at vblank), a sequencer copies the shadow bank into the active bank, one sprite per cycle.
- The renderer reads the active bank by sprite index, so host writes are never half-visible mid-frame.

Parameters:
- NUM_SPRITES, 16, number of sprites; must be a power of 2.
- SPRITE_INDEX_BITS, 4, log2(NUM_SPRITES).
- NUM_SPRITE_REGS, 8, registers per sprite (CTRL0, CTRL1, DATA_OFFSET, REF_XY, COLOR_KEY, OFFSET_X, OFFSET_Y, spare).
- REG_INDEX_BITS, 3, log2(NUM_SPRITE_REGS).
- REG_DATA_WIDTH, 16, bits per register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- _reset  in  1  asynchronous, active-low reset.
- host_en  in  1  host access strobe; no access when low.
- host_wr  in  1  write qualifier (with host_en).
- host_rd  in  1  read qualifier (with host_en).
- host_addr  in  SPRITE_INDEX_BITS+REG_INDEX_BITS  {sprite index, reg index}; reg index in the low bits.
- host_data_in  in  REG_DATA_WIDTH  write data.
- host_data_out  out  REG_DATA_WIDTH  shadow-bank read data.
- commit_req  in  1  single-cycle pulse requesting shadow-to-active copy.
- commit_busy  out  1  high while the copy is in progress.
- commit_done  out  1  one-cycle pulse when the copy completes.
- disp_index  in  SPRITE_INDEX_BITS  sprite selected by the renderer.
- disp_reg_values  out  NUM_SPRITE_REGS*REG_DATA_WIDTH  active-bank registers of the selected sprite; reg i occupies bits [(i+1)*W-1 : i*W].

Behaviour:
- Reset (async, _reset low): shadow bank, active bank, host_data_out, disp_reg_values, commit_busy, commit_done and copy index all 0; state IDLE. Reset mid-copy aborts the copy immediately; no partial commit survives.
- Host write: host_en&host_wr at edge N. shadow[sprite][reg] = host_data_in after edge N. Accepted in any state; no wait states.
- Host read: host_en&host_rd at edge N. host_data_out = shadow[sprite][reg] after edge N (1-cycle latency). host_data_out holds its value until the next read.
- Host read and write in the same cycle: the write is performed; host_data_out returns the pre-write value.
- Display read: disp_reg_values = active[disp_index] registered, 1-cycle latency, updated every cycle. It reflects the active bank as of the previous edge.
- FSM has two states, IDLE and COPY.
- IDLE, commit_req=1: go to COPY; copy index k=0; commit_busy=1 from the next cycle.
- COPY, each cycle: active[k] <= shadow[k] (all NUM_SPRITE_REGS regs), then k++.
- COPY, k=NUM_SPRITES-1: after that copy, go to IDLE, commit_busy=0 and commit_done=1 for exactly one cycle.
- Copy duration: busy for exactly NUM_SPRITES cycles.
- commit_req while in COPY, or on the done cycle when the FSM is still COPY: ignored; no queuing.
- Host write during COPY to sprite s:
  - s>k (not yet copied): the new value is included in this commit.
  - s<k (already copied): the value stays in shadow until the next commit.
  - s==k (same cycle): active receives the pre-write shadow value; the new value is deferred to the next commit.
- Index arithmetic: k is SPRITE_INDEX_BITS wide; termination is detected by k==NUM_SPRITES-1, not by wraparound. Address fields are fully decoded; no out-of-range addresses exist.
- The active bank is never written by the host.

Test Plan:
- Reset then read: read addr 0x00 and 0x7F -> host_data_out=0x0000; disp_reg_values=0 for every disp_index; commit_busy=0.
- Shadow isolation: write sprite 3 reg 0 = 0x0001 with no commit; disp_index=3 -> disp_reg_values[15:0]=0x0000; host read of addr 0x18 -> 0x0001.
- Commit: write sprite 3 reg 1 = 0x0005, pulse commit_req -> busy high for exactly 16 cycles, commit_done pulses once; disp_index=3 -> reg0=0x0001, reg1=0x0005.
- Concurrent writes during COPY:
  - Write sprite 0 reg 0 = 0xAAAA at k=5 -> not active after done; active after a second commit.
  - Write sprite 12 reg 0 = 0xBBBB at k=5 -> active after this commit.
  - Write sprite 7 at k=7 -> deferred to the next commit.
- Ignored request: pulse commit_req at k=8 -> busy still ends after 16 total cycles; exactly one commit_done; no restart.
- Reset mid-copy: assert _reset at k=4 -> all outputs 0 immediately, FSM IDLE; after release, active and shadow reads are all 0.
